// File: rtl/mag_pkg.sv
// Shared definitions for the magnitude datapath: sample width, default alarm
// thresholds, windowed-stats FSM states and small compare helpers.
package mag_pkg;

  localparam int unsigned MAG_W        = 8;
  localparam int unsigned ALARM_HI_DEF = 200;
  localparam int unsigned ALARM_LO_DEF = 180;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_e;

  function automatic logic [MAG_W-1:0] mag_max(input logic [MAG_W-1:0] a,
                                               input logic [MAG_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [MAG_W-1:0] mag_min(input logic [MAG_W-1:0] a,
                                               input logic [MAG_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/mag_window_stats_if.sv
// Sample-in / window-result-out handshake bundle for mag_window_stats.
interface mag_window_stats_if;

  logic                     in_valid;
  logic [mag_pkg::MAG_W-1:0] in_mag;
  logic                     in_ready;
  logic                     clear;
  logic                     out_valid;
  logic                     out_ready;
  logic [mag_pkg::MAG_W-1:0] out_avg;
  logic [mag_pkg::MAG_W-1:0] out_max;
  logic [mag_pkg::MAG_W-1:0] out_min;
  logic                     alarm;

  modport master (
    output in_valid, in_mag, clear, out_ready,
    input  in_ready, out_valid, out_avg, out_max, out_min, alarm
  );

  modport slave (
    input  in_valid, in_mag, clear, out_ready,
    output in_ready, out_valid, out_avg, out_max, out_min, alarm
  );

endinterface

// File: rtl/mag_alarm_hyst.sv
// Registered hysteresis comparator: sets at/above ALARM_HI, clears at/below
// ALARM_LO, holds in between; only evaluated on enabled samples.
module mag_alarm_hyst
  import mag_pkg::*;
#(
  parameter int unsigned ALARM_HI = ALARM_HI_DEF,
  parameter int unsigned ALARM_LO = ALARM_LO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [MAG_W-1:0] mag,
  output logic             alarm
);

  localparam logic [MAG_W-1:0] HI = MAG_W'(ALARM_HI);
  localparam logic [MAG_W-1:0] LO = MAG_W'(ALARM_LO);

  logic r_alarm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alarm <= 1'b0;
    end else if (sample_en) begin
      if (mag >= HI) begin
        r_alarm <= 1'b1;
      end else if (mag <= LO) begin
        r_alarm <= 1'b0;
      end
    end
  end

  assign alarm = r_alarm;

endmodule

// File: rtl/mag_window_stats.sv
// Windowed average/max/min over 2^LOG2_WIN accepted magnitudes, presented on a
// valid/ready result port, plus a per-sample hysteresis alarm.
module mag_window_stats
  import mag_pkg::*;
#(
  parameter int unsigned LOG2_WIN = 4,
  parameter int unsigned ALARM_HI = ALARM_HI_DEF,
  parameter int unsigned ALARM_LO = ALARM_LO_DEF
) (
  input logic              clk,
  input logic              rst,
  mag_window_stats_if.slave bus
);

  localparam int unsigned WIN   = 1 << LOG2_WIN;
  localparam int unsigned SUM_W = MAG_W + LOG2_WIN;
  localparam int unsigned CNT_W = LOG2_WIN + 1;

  state_e             r_state;
  logic [SUM_W-1:0]   r_sum;
  logic [MAG_W-1:0]   r_max;
  logic [MAG_W-1:0]   r_min;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic [MAG_W-1:0]   r_out_avg;
  logic [MAG_W-1:0]   r_out_max;
  logic [MAG_W-1:0]   r_out_min;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_last;
  logic [SUM_W-1:0]   w_sum_next;
  logic [MAG_W-1:0]   w_max_next;
  logic [MAG_W-1:0]   w_min_next;
  logic               w_alarm;

  // Ready is combinational so reset and clear block acceptance in the same cycle.
  assign w_in_ready = (r_state == ACCUM) && !bus.clear && !rst;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last     = (r_cnt == CNT_W'(WIN - 1));

  // Window stats including the sample offered this cycle.
  assign w_sum_next = r_sum + SUM_W'(bus.in_mag);
  assign w_max_next = mag_max(r_max, bus.in_mag);
  assign w_min_next = mag_min(r_min, bus.in_mag);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_sum       <= '0;
      r_max       <= '0;
      r_min       <= '1;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_avg   <= '0;
      r_out_max   <= '0;
      r_out_min   <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (bus.clear) begin
            r_sum <= '0;
            r_max <= '0;
            r_min <= '1;
            r_cnt <= '0;
          end else if (w_accept) begin
            if (w_last) begin
              r_out_avg   <= MAG_W'(w_sum_next >> LOG2_WIN);
              r_out_max   <= w_max_next;
              r_out_min   <= w_min_next;
              r_out_valid <= 1'b1;
              r_sum       <= '0;
              r_max       <= '0;
              r_min       <= '1;
              r_cnt       <= '0;
              r_state     <= REPORT;
            end else begin
              r_sum <= w_sum_next;
              r_max <= w_max_next;
              r_min <= w_min_next;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        REPORT: begin
          // Clear abandons the result; otherwise wait for the consumer.
          if (bus.clear || bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  mag_alarm_hyst #(
    .ALARM_HI (ALARM_HI),
    .ALARM_LO (ALARM_LO)
  ) u_alarm (
    .clk       (clk),
    .rst       (rst),
    .sample_en (w_accept),
    .mag       (bus.in_mag),
    .alarm     (w_alarm)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_avg   = r_out_avg;
  assign bus.out_max   = r_out_max;
  assign bus.out_min   = r_out_min;
  assign bus.alarm     = w_alarm;

endmodule
